// File: rtl/cosine_cordic_if.sv
// Request/response bundle for the CORDIC cosine unit.
interface cosine_cordic_if #(
  parameter int WIDTH = 24
);
  logic             start;
  logic [31:0]      angle;
  logic             busy;
  logic             valid;
  logic [31:0]      result;
  logic [WIDTH+1:0] theta;

  modport master (output start, angle, input busy, valid, result, theta);
  modport slave  (input start, angle, output busy, valid, result, theta);
endinterface

// File: rtl/cosine_cordic.sv
// Iterative rotation-mode CORDIC cosine: float angle -> fixed, WIDTH
// micro-rotations (one per clock), fixed -> float on the final x.
// The atan ROM and float<->fixed shifters are sized for WIDTH=24.
module cosine_cordic #(
  parameter int WIDTH = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  cosine_cordic_if.slave bus
);
  localparam int W2 = WIDTH + 2;
  localparam int IW = $clog2(WIDTH);
  localparam int LW = $clog2(W2);
  localparam logic [W2-1:0] K_INIT = W2'(24'h9B74EE);
  localparam logic [31:0]   QNAN   = 32'h7FC0_0000;
  localparam logic [7:0]    EXP_LO = 8'(127 - WIDTH);

  typedef enum logic [1:0] {IDLE, CONVERT, ITERATE, PACK} state_t;
  state_t state, state_nx;

  logic [31:0]          angle_q;
  logic [W2-1:0]        theta_q;
  logic signed [W2-1:0] x, y, z;
  logic [IW-1:0]        iter;
  logic                 nan_q;
  logic                 valid_q;
  logic [31:0]          result_q;
  logic                 accept;

  // atan(2^-i) in WIDTH fractional bits, rounded to nearest; beyond i=8
  // the series correction is below half an LSB so the entry is 2^(WIDTH-i)
  function automatic logic [W2-1:0] atan_rom(input logic [IW-1:0] i);
    case (i)
      IW'(0):  atan_rom = W2'(24'hC90FDB);
      IW'(1):  atan_rom = W2'(24'h76B19C);
      IW'(2):  atan_rom = W2'(24'h3EB6EC);
      IW'(3):  atan_rom = W2'(24'h1FD5BB);
      IW'(4):  atan_rom = W2'(24'h0FFAAE);
      IW'(5):  atan_rom = W2'(24'h07FF55);
      IW'(6):  atan_rom = W2'(24'h03FFEB);
      IW'(7):  atan_rom = W2'(24'h01FFFD);
      IW'(8):  atan_rom = W2'(24'h010000);
      default: atan_rom = W2'(1) << (WIDTH - int'(i));
    endcase
  endfunction

  // busy covers the whole run including PACK, so a start in the PACK
  // cycle is dropped and the next accept lands on the valid cycle
  assign accept     = bus.start && (state == IDLE);
  assign bus.busy   = (state != IDLE);
  assign bus.valid  = valid_q;
  assign bus.result = result_q;
  assign bus.theta  = theta_q;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = CONVERT;
      CONVERT: state_nx = ITERATE;
      ITERATE: if (iter == IW'(WIDTH - 1)) state_nx = PACK;
      PACK:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // float -> fixed: magnitude truncated toward zero, clamped near 2.0
  logic [7:0]    cv_exp;
  logic [22:0]   cv_mant;
  logic [W2-2:0] cv_mag;
  logic [W2-1:0] theta_c;
  logic          nan_c;
  always_comb begin
    cv_exp  = angle_q[30:23];
    cv_mant = angle_q[22:0];
    nan_c   = (cv_exp == 8'hFF) && (cv_mant != '0);
    if (cv_exp < EXP_LO)        cv_mag = '0;
    else if (cv_exp >= 8'd128)  cv_mag = '1;
    else                        cv_mag = {1'b1, cv_mant, 1'b0} >> (8'd127 - cv_exp);
    theta_c = angle_q[31] ? W2'(-{1'b0, cv_mag}) : {1'b0, cv_mag};
  end

  // one micro-rotation, direction from the sign of the residual angle
  logic signed [W2-1:0] x_nx, y_nx, z_nx, xs, ys, at;
  always_comb begin
    xs = x >>> iter;
    ys = y >>> iter;
    at = atan_rom(iter);
    if (!z[W2-1]) begin
      x_nx = x - ys;
      y_nx = y + xs;
      z_nx = z - at;
    end else begin
      x_nx = x + ys;
      y_nx = y - xs;
      z_nx = z + at;
    end
  end

  // fixed -> float on final x: leading-one normalise, truncate mantissa
  logic [W2-1:0] pk_mag, pk_norm;
  logic [LW-1:0] pk_lead;
  logic [31:0]   pack_c;
  always_comb begin
    pk_mag  = x[W2-1] ? W2'(-x) : W2'(x);
    pk_lead = '0;
    for (int p = 0; p < W2; p++) if (pk_mag[p]) pk_lead = LW'(p);
    pk_norm = pk_mag << (LW'(W2 - 1) - pk_lead);
    if (pk_mag == '0) pack_c = '0;
    else              pack_c = {x[W2-1], EXP_LO + 8'(pk_lead), pk_norm[W2-2 -: 23]};
  end

  // datapath registers, advanced by the FSM phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle_q <= '0;
      theta_q <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      iter    <= '0;
      nan_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) angle_q <= bus.angle;
        CONVERT: begin
          theta_q <= theta_c;
          x       <= K_INIT;
          y       <= '0;
          z       <= theta_c;
          iter    <= '0;
          nan_q   <= nan_c;
        end
        ITERATE: begin
          x    <= x_nx;
          y    <= y_nx;
          z    <= z_nx;
          iter <= iter + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // result/valid: updated only on the PACK -> IDLE transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= (state == PACK);
      if (state == PACK) result_q <= nan_q ? QNAN : pack_c;
    end
  end
endmodule

// File: tb/tb_cosine_cordic.sv
// Directed + random bench for cosine_cordic against a real-arithmetic model.
module tb_cosine_cordic;
  logic clk, rst_n;
  int   vectors, miscompares;
  real  sat_lim;

  cosine_cordic_if #(.WIDTH(24)) bus ();
  cosine_cordic #(.WIDTH(24)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return b[31] ? -m : m;
  endfunction

  function automatic logic [25:0] theta_ref(input logic [31:0] a);
    real v;
    int  q;
    v = f2r(a);
    if (v < 0.0) v = -v;
    v = v * 16777216.0;
    if (a[30:23] == 8'hFF || v >= 33554431.0) q = 33554431;
    else q = $rtoi(v);
    return a[31] ? 26'(-q) : 26'(q);
  endfunction

  function automatic real cos_ref(input logic [31:0] a);
    real v;
    v = f2r(a);
    if (v > sat_lim)  v = sat_lim;
    if (v < -sat_lim) v = -sat_lim;
    return $cos(v);
  endfunction

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_tol(input string tag, input logic [31:0] obs, input real expv, input real tol);
    real o, d;
    bit  ok;
    o  = f2r(obs);
    d  = (o > expv) ? o - expv : expv - o;
    ok = (d <= tol) && (obs[30:23] != 8'hFF);
    vectors++;
    assert (ok === 1'b1) else begin
      miscompares++;
      $error("FAIL %s observed=%h (%f) expected=%f", tag, obs, o, expv);
    end
  endtask

  // mode 0: tight accuracy, 1: saturated angle, 2: NaN
  task automatic run_check(input string tag, input logic [31:0] a, input int mode);
    int lat;
    bit busy_ok;
    logic [31:0] res;
    bus.start = 1'b1;
    bus.angle = a;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.angle = $urandom;
    @(posedge clk); #1;
    chk_eq({tag, " theta"}, 64'(bus.theta), 64'(theta_ref(a)));
    lat = 1;
    busy_ok = bus.busy && !bus.valid;
    while (!bus.valid && lat < 60) begin
      if (lat == 6) begin bus.start = 1'b1; bus.angle = $urandom; end
      if (lat == 7) bus.start = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (!bus.valid && !bus.busy) busy_ok = 1'b0;
    end
    chk_eq({tag, " latency"}, 64'(lat), 64'd26);
    chk_eq({tag, " busy_run"}, 64'(busy_ok), 64'd1);
    chk_eq({tag, " busy_at_valid"}, 64'(bus.busy), 64'd0);
    res = bus.result;
    case (mode)
      0: chk_tol({tag, " result"}, res, $cos(f2r(a)), 2.0 ** -20);
      1: chk_tol({tag, " result"}, res, cos_ref(a), 2.0 ** -18);
      default: chk_eq({tag, " result"}, 64'(res), 64'h7FC00000);
    endcase
    @(posedge clk); #1;
    chk_eq({tag, " valid_fall"}, 64'(bus.valid), 64'd0);
  endtask

  initial begin
    int nvalid, first, second, cyc;
    logic [31:0] a;
    logic [7:0]  e;
    logic [22:0] m;
    vectors = 0;
    miscompares = 0;
    sat_lim = 0.0;
    for (int i = 0; i < 24; i++) sat_lim += $atan(2.0 ** (-i));

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.angle = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset busy", 64'(bus.busy), 64'd0);
    chk_eq("reset valid", 64'(bus.valid), 64'd0);
    chk_eq("reset result", 64'(bus.result), 64'd0);
    chk_eq("reset theta", 64'(bus.theta), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_check("pos_one", 32'h3F800000, 0);
    chk_eq("pos_one theta_const", 64'(bus.theta), 64'h1000000);
    run_check("neg_one", 32'hBF800000, 0);
    chk_eq("neg_one theta_const", 64'(bus.theta), 64'h3000000);
    run_check("zero", 32'h00000000, 0);
    vectors++;
    assert (bus.result >= 32'h3F7FFFF0) else begin
      miscompares++;
      $error("FAIL zero near_one observed=%h expected>=3f7ffff0", bus.result);
    end
    run_check("tiny", 32'h33800000, 0);
    chk_eq("tiny theta_const", 64'(bus.theta), 64'h0000001);
    run_check("half", 32'h3F000000, 0);
    run_check("sat_175", 32'h3FE00000, 1);
    chk_eq("sat_175 sign", 64'(bus.result[31]), 64'd1);
    run_check("nan", 32'h7FC00001, 2);

    for (int k = 0; k < 16; k++) begin
      e = 8'($urandom_range(100, 127));
      m = 23'($urandom);
      if (e == 8'd127) m = 23'(m % 23'd5872025);
      a = {1'($urandom), e, m};
      run_check($sformatf("rand%0d", k), a, 0);
    end
    for (int k = 0; k < 4; k++) begin
      a = {1'($urandom), 8'($urandom_range(128, 140)), 23'($urandom)};
      run_check($sformatf("rsat%0d", k), a, 1);
    end

    // reset in the middle of a run: no completion may follow
    bus.start = 1'b1;
    bus.angle = 32'h3F800000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk_eq("abort busy", 64'(bus.busy), 64'd0);
    chk_eq("abort valid", 64'(bus.valid), 64'd0);
    chk_eq("abort result", 64'(bus.result), 64'd0);
    chk_eq("abort theta", 64'(bus.theta), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    nvalid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.valid) nvalid++;
    end
    chk_eq("abort no_valid", 64'(nvalid), 64'd0);
    run_check("restart", 32'h3F800000, 0);

    // start held high: results every WIDTH+3 cycles
    bus.angle = 32'h3F000000;
    bus.start = 1'b1;
    first = -1;
    second = -1;
    cyc = 0;
    while (second < 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.valid) begin
        if (first < 0) first = cyc;
        else second = cyc;
      end
    end
    bus.start = 1'b0;
    chk_eq("b2b first", 64'(first), 64'd27);
    chk_eq("b2b period", 64'(second - first), 64'd27);
    chk_tol("b2b result", bus.result, $cos(0.5), 2.0 ** -20);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
